branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/branch_cmp.sv | 24 ++
 rtl/branch_resolve_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V types and constants for the branch resolve unit
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BRU_IDLE     = 2'd0,
    BRU_REDIRECT = 2'd1,
    BRU_HOLD     = 2'd2
  } bru_state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // 010 and 011 are not branch encodings; everything else is
  function automatic logic is_legal_branch(input logic [2:0] funct3);
    return funct3[2] | ~funct3[1];
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational branch condition evaluation
module branch_cmp
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [2:0]      funct3,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_val == rs2_val);
      F3_BNE:  taken = (rs1_val != rs2_val);
      F3_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: taken = (rs1_val <  rs2_val);
      F3_BGEU: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolution, redirect FSM, BTB update and stats
module branch_resolve_unit
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1_val,
  input  logic [XLEN-1:0] ex_rs2_val,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  input  logic            pc_stall,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            flush,
  output logic            btb_update_en,
  output logic [XLEN-1:0] btb_pc_update,
  output logic [XLEN-1:0] btb_target_actual,
  output logic            btb_is_branch_or_jmp,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  bru_state_e      state_q;
  logic            cmp_taken;
  logic            resolve;
  logic            taken;
  logic            mispredict;
  logic            btb_upd;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;

  branch_cmp u_branch_cmp (
    .rs1_val (ex_rs1_val),
    .rs2_val (ex_rs2_val),
    .funct3  (ex_funct3),
    .taken   (cmp_taken)
  );

  always_comb begin
    resolve    = ex_valid && (state_q == BRU_IDLE) && (ex_is_branch || ex_is_jal || ex_is_jalr);
    taken      = ex_is_branch ? cmp_taken : 1'b1;
    jalr_sum   = ex_rs1_val + ex_imm;
    target     = ex_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
    next_pc    = taken ? target : (ex_pc + XLEN'(4));
    mispredict = (taken != ex_pred_taken) || (taken && (target != ex_pred_target));
    // non-branch funct3 encodings still count as resolved, but must not train the BTB
    btb_upd    = resolve && !(ex_is_branch && !is_legal_branch(ex_funct3));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BRU_IDLE;
      branch_taken  <= 1'b0;
      flush         <= 1'b0;
      branch_target <= '0;
    end else begin
      case (state_q)
        BRU_IDLE: begin
          if (resolve && mispredict) begin
            state_q       <= BRU_REDIRECT;
            branch_taken  <= 1'b1;
            flush         <= 1'b1;
            branch_target <= next_pc;
          end
        end
        BRU_REDIRECT, BRU_HOLD: begin
          if (!pc_stall) begin
            state_q      <= BRU_IDLE;
            branch_taken <= 1'b0;
            flush        <= 1'b0;
          end else begin
            state_q <= BRU_HOLD;
          end
        end
        default: begin
          state_q      <= BRU_IDLE;
          branch_taken <= 1'b0;
          flush        <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btb_update_en        <= 1'b0;
      btb_pc_update        <= '0;
      btb_target_actual    <= '0;
      btb_is_branch_or_jmp <= 1'b0;
      stat_branches        <= '0;
      stat_mispredicts     <= '0;
    end else begin
      btb_update_en <= btb_upd;
      if (btb_upd) begin
        btb_pc_update        <= ex_pc;
        btb_target_actual    <= target;
        btb_is_branch_or_jmp <= taken;
      end
      if (resolve && (stat_branches != '1)) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (resolve && mispredict && (stat_mispredicts != '1)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule
